// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_pkg
// Purpose  : Shared access-size encodings, init FSM state type and a helper
//            that maps an access size to its byte count.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

   // Access size encodings carried on the Size port
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Init sequencer states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_INIT = 1'b1
   } init_state_t;

   // Number of bytes touched by an access; the illegal code is treated as a
   // word so the range check stays conservative (it faults regardless).
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_init_sequencer
// Purpose  : IDLE/INIT state machine that walks every aligned word of the
//            memory once, one word per cycle, after an init request.
// Revision : 1.0 - initial release
// ============================================================================
module mem_init_sequencer
   import data_mem_pkg::*;
#(
   parameter int unsigned WORDS = 64,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   output logic             busy_o,
   output logic             wr_en_o,
   output logic [CNT_W-1:0] word_addr_o
);

   localparam logic [CNT_W-1:0] c_LAST_WORD = CNT_W'(WORDS - 1);

   init_state_t      state_q;
   logic [CNT_W-1:0] cnt_q;

   // State and word counter; start requests are only honoured in IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (start_i) begin
                  state_q <= ST_INIT;
               end
            end
            ST_INIT: begin
               if (cnt_q == c_LAST_WORD) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Every INIT cycle writes the word the counter points at
   assign busy_o      = (state_q == ST_INIT);
   assign wr_en_o     = (state_q == ST_INIT);
   assign word_addr_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_unit
// Purpose  : Big-endian byte-addressed data memory with byte/half/word
//            access, alignment and range fault detection, and a hardware
//            init sequence that fills every word with INIT_WORD.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_unit
   import data_mem_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES = 256,
   parameter logic [31:0] INIT_WORD   = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Startin,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Fault,
   output logic        FaultSticky
);

   localparam int unsigned c_ADDR_W = $clog2(DEPTH_BYTES);
   localparam int unsigned c_WORDS  = DEPTH_BYTES / 4;
   localparam int unsigned c_CNT_W  = c_ADDR_W - 2;

   logic [7:0]          mem_q [0:DEPTH_BYTES-1];
   logic                faultsticky_q;

   logic                seq_busy;
   logic                seq_wr_en;
   logic [c_CNT_W-1:0]  seq_word;

   logic [32:0]         w_last_byte;
   logic                w_misaligned;
   logic                w_out_of_range;
   logic                w_store;
   logic                w_init_we;
   logic                w_sx;
   logic [c_ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3, w_ia;
   logic [7:0]          w_b0, w_b1, w_b2, w_b3;

   mem_init_sequencer #(
      .WORDS (c_WORDS),
      .CNT_W (c_CNT_W)
   ) u_init_seq (
      .clk         (clk),
      .rst         (rst),
      .start_i     (Startin),
      .busy_o      (seq_busy),
      .wr_en_o     (seq_wr_en),
      .word_addr_o (seq_word)
   );

   // Fault detection: 33-bit end address so high addresses never wrap in range
   assign w_last_byte    = {1'b0, Address} + {30'b0, size_bytes(Size)} - 33'd1;
   assign w_out_of_range = (w_last_byte >= 33'(DEPTH_BYTES));
   assign w_misaligned   = ((Size == SZ_HALF) && Address[0])
                        || ((Size == SZ_WORD) && (Address[1:0] != 2'b00))
                        || (Size == 2'b11);
   assign Fault          = (MemRead || MemWrite) && (w_misaligned || w_out_of_range);

   assign Ready       = !seq_busy && !rst;
   assign FaultSticky = faultsticky_q;

   // A store needs IDLE, no fault, and no init request in the same cycle
   assign w_store   = Ready && MemWrite && !Fault && !Startin;
   assign w_init_we = seq_wr_en && !rst;
   assign w_ia      = {seq_word, 2'b00};

   // Byte lanes in address order; lane 0 is the most significant byte
   assign w_a0 = Address[c_ADDR_W-1:0];
   assign w_a1 = w_a0 + c_ADDR_W'(1);
   assign w_a2 = w_a0 + c_ADDR_W'(2);
   assign w_a3 = w_a0 + c_ADDR_W'(3);
   assign w_b0 = mem_q[w_a0];
   assign w_b1 = mem_q[w_a1];
   assign w_b2 = mem_q[w_a2];
   assign w_b3 = mem_q[w_a3];
   assign w_sx = !Unsigned && w_b0[7];

   // Load path: pre-write contents, extended per Size/Unsigned, zero otherwise
   always_comb begin
      ReadData = 32'h0;
      if (MemRead && Ready && !Fault) begin
         case (Size)
            SZ_BYTE: ReadData = {{24{w_sx}}, w_b0};
            SZ_HALF: ReadData = {{16{w_sx}}, w_b0, w_b1};
            SZ_WORD: ReadData = {w_b0, w_b1, w_b2, w_b3};
            default: ReadData = 32'h0;
         endcase
      end
   end

   // Storage: init fill has priority, then big-endian byte/half/word stores
   always_ff @(posedge clk) begin
      if (w_init_we) begin
         mem_q[w_ia]                   <= INIT_WORD[31:24];
         mem_q[w_ia + c_ADDR_W'(1)]    <= INIT_WORD[23:16];
         mem_q[w_ia + c_ADDR_W'(2)]    <= INIT_WORD[15:8];
         mem_q[w_ia + c_ADDR_W'(3)]    <= INIT_WORD[7:0];
      end else if (w_store) begin
         case (Size)
            SZ_BYTE: begin
               mem_q[w_a0] <= WriteData[7:0];
            end
            SZ_HALF: begin
               mem_q[w_a0] <= WriteData[15:8];
               mem_q[w_a1] <= WriteData[7:0];
            end
            default: begin
               mem_q[w_a0] <= WriteData[31:24];
               mem_q[w_a1] <= WriteData[23:16];
               mem_q[w_a2] <= WriteData[15:8];
               mem_q[w_a3] <= WriteData[7:0];
            end
         endcase
      end
   end

   // Sticky fault: cleared by reset or init entry, set by faulting IDLE cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         faultsticky_q <= 1'b0;
      end else if (!seq_busy && Startin) begin
         faultsticky_q <= 1'b0;
      end else if (!seq_busy && Fault) begin
         faultsticky_q <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_unit
// Purpose  : Self-checking bench for data_memory_unit against a byte-array
//            reference model driven by directed and random accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_unit;

   localparam int          DEPTH = 256;
   localparam logic [31:0] IW    = 32'h0000_0001;

   logic        clk = 1'b0;
   logic        rst, Startin, MemWrite, MemRead, Unsigned;
   logic [31:0] Address, WriteData, ReadData;
   logic [1:0]  Size;
   logic        Ready, Fault, FaultSticky;

   always #5 clk = ~clk;

   data_memory_unit #(
      .DEPTH_BYTES (DEPTH),
      .INIT_WORD   (IW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .Startin     (Startin),
      .Address     (Address),
      .WriteData   (WriteData),
      .MemWrite    (MemWrite),
      .MemRead     (MemRead),
      .Size        (Size),
      .Unsigned    (Unsigned),
      .ReadData    (ReadData),
      .Ready       (Ready),
      .Fault       (Fault),
      .FaultSticky (FaultSticky)
   );

   // Reference model state
   logic [7:0] mdl [DEPTH];
   bit         m_sticky;
   int         checks   = 0;
   int         failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit mdl_fault(input bit rd, input bit wr, input logic [31:0] a,
                                    input logic [1:0] sz);
      logic [63:0] last;
      if (!(rd || wr)) return 1'b0;
      if (sz == 2'b11) return 1'b1;
      if ((a % nbytes(sz)) != 0) return 1'b1;
      last = {32'd0, a} + 64'(nbytes(sz)) - 64'd1;
      return (last >= 64'(DEPTH));
   endfunction

   function automatic logic [31:0] mdl_read(input logic [31:0] a, input logic [1:0] sz,
                                            input bit uns);
      logic [31:0] v;
      int          n;
      n = nbytes(sz);
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mdl[int'(a) + i]};
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   function automatic void mdl_write(input logic [31:0] a, input logic [1:0] sz,
                                     input logic [31:0] wd);
      int n;
      n = nbytes(sz);
      for (int i = 0; i < n; i++) mdl[int'(a) + i] = 8'(wd >> (8*(n-1-i)));
   endfunction

   // One IDLE/reset cycle: drive, check combinational outputs, advance model
   task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit uns, input bit st, input bit r,
                       input string tag);
      bit          f;
      logic [31:0] rexp;
      @(negedge clk);
      rst = r; Startin = st; MemRead = rd; MemWrite = wr;
      Address = a; WriteData = wd; Size = sz; Unsigned = uns;
      #1;
      f    = mdl_fault(rd, wr, a, sz);
      rexp = 32'h0;
      if (rd && !r && !f) rexp = mdl_read(a, sz, uns);
      check({tag, ".ready"},  {31'b0, Ready},       {31'b0, !r});
      check({tag, ".fault"},  {31'b0, Fault},       {31'b0, f});
      check({tag, ".rdata"},  ReadData,             rexp);
      check({tag, ".sticky"}, {31'b0, FaultSticky}, {31'b0, m_sticky});
      @(posedge clk);
      if (r || st) begin
         m_sticky = 1'b0;
      end else begin
         if (f) m_sticky = 1'b1;
         if (wr && !f) mdl_write(a, sz, wd);
      end
   endtask

   // Init request (with a store that must be dropped), then the fill cycles;
   // abort_at >= 0 asserts rst during that fill cycle.
   task automatic run_init(input int abort_at);
      bit f, r;
      step(1'b0, 1'b1, 32'hF0, $urandom, 2'b10, 1'b0, 1'b1, 1'b0, "init_req");
      for (int k = 0; k < DEPTH/4; k++) begin
         r = (k == abort_at);
         @(negedge clk);
         rst = r; Startin = (k == 5); MemRead = 1'b1; MemWrite = 1'b1;
         Address = (k == 3) ? 32'h13 : 32'h80; WriteData = $urandom;
         Size = 2'b10; Unsigned = 1'b0;
         #1;
         f = mdl_fault(1'b1, 1'b1, Address, 2'b10);
         check("init.ready",  {31'b0, Ready},       32'h0);
         check("init.rdata",  ReadData,             32'h0);
         check("init.fault",  {31'b0, Fault},       {31'b0, f});
         check("init.sticky", {31'b0, FaultSticky}, {31'b0, m_sticky});
         @(posedge clk);
         if (r) begin
            m_sticky = 1'b0;
            break;
         end
         for (int b = 0; b < 4; b++) mdl[4*k + b] = 8'(IW >> (8*(3-b)));
      end
   endtask

   initial begin
      logic [31:0] ra;
      rst = 1'b1; Startin = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      Address = 32'h0; WriteData = 32'h0; Size = 2'b10; Unsigned = 1'b0;
      m_sticky = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state
      step(1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b1, 1'b1, "reset");

      // Full init, then every word reads INIT_WORD
      run_init(-1);
      for (int w = 0; w < DEPTH/4; w++)
         step(1'b1, 1'b0, 32'(4*w), 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, "init_rd");

      // Byte loads of a stored word, signed and unsigned
      step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 1'b0, "st_w10");
      step(1'b1, 1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, "ldb_s");
      step(1'b1, 1'b0, 32'h11, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, "ldb_u");
      step(1'b1, 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 1'b0, 1'b0, "ldh_s");

      // Half store into the low half of a word
      step(1'b0, 1'b1, 32'h22, 32'h00001234, 2'b01, 1'b0, 1'b0, 1'b0, "st_h22");
      step(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, "ld_w20");

      // Misaligned store, out-of-range load, sticky
      step(1'b0, 1'b1, 32'h13, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0, 1'b0, "st_mis");
      step(1'b1, 1'b0, 32'hFE, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, "ld_oor");
      step(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, "ld_w10");

      // Range boundaries and no wrap-around of high addresses
      step(1'b1, 1'b0, 32'hFC, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, "ld_fc");
      step(1'b1, 1'b0, 32'hFE, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, "ld_fe_h");
      step(1'b1, 1'b0, 32'hFF, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, "ld_ff_b");
      step(1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, "ld_100");
      step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, "ld_top_b");
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1, 2'b10, 1'b0, 1'b0, 1'b0, "st_top_w");
      step(1'b1, 1'b0, 32'h21, 32'h0, 2'b01, 1'b0, 1'b0, 1'b0, "ld_h_odd");
      step(1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, "ld_sz11");

      // Read and write to the same address in one cycle
      step(1'b1, 1'b1, 32'h40, 32'h55, 2'b10, 1'b0, 1'b0, 1'b0, "rw_40");
      step(1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, "rd_40");

      // Store during reset is suppressed; reset clears sticky
      step(1'b1, 1'b1, 32'h44, 32'h77777777, 2'b10, 1'b0, 1'b0, 1'b1, "rst_st");
      step(1'b1, 1'b0, 32'h44, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, "rd_44");

      // Randomized traffic, including occasional reset cycles
      for (int i = 0; i < 300; i++) begin
         ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 3));
         step(1'($urandom), 1'($urandom), ra, $urandom, 2'($urandom), 1'($urandom),
              1'b0, ($urandom_range(0, 39) == 0), "rand");
      end

      // Distinct pattern in every word, a fault, then an aborted init
      for (int w = 0; w < DEPTH/4; w++)
         step(1'b0, 1'b1, 32'(4*w), 32'hA500_0000 | 32'(w), 2'b10, 1'b0, 1'b0, 1'b0, "fill");
      step(1'b1, 1'b0, 32'h13, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, "pre_abort");
      run_init(10);
      for (int w = 0; w < DEPTH/4; w++)
         step(1'b1, 1'b0, 32'(4*w), 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, "abort_rd");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
